// File: rtl/exotiny_console_tx.sv
// ExoTiny console sink: Wishbone byte writes at 0xC are queued and sent as 8N1 UART.
// The last four bytes written are matched against "DONE"/"ERR" to drive sticky status pins.
module exotiny_console_tx #(
    parameter int CLKDIV    = 217,
    parameter int FIFODEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        txd_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int AW = $clog2(FIFODEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [15:0] CNT_END = 16'(CLKDIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]  r_mem [FIFODEPTH];
    logic [AW:0] r_wptr, r_rptr;
    logic        r_ack;
    logic [31:0] r_dat;
    logic [31:0] r_sig;
    logic        r_pushd, r_done, r_err;
    state_t      r_state, w_state_n;
    logic [15:0] r_cnt, w_cnt_n;
    logic [2:0]  r_bit, w_bit_n;
    logic [7:0]  r_shift, w_shift_n;
    logic        r_txd, w_txd_n;

    logic        w_empty, w_full, w_pop, w_push, w_stall, w_acc;
    logic        w_sel, w_tx, w_st, w_clr, w_busy, w_end;
    logic        w_set_d, w_set_e;
    logic [31:0] w_rdata;
    logic [7:0]  w_head;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_head  = r_mem[r_rptr[AW-1:0]];
    assign w_busy  = (r_state != S_IDLE) | ~w_empty;

    assign w_sel   = wb_stb_i & ~r_ack;
    assign w_tx    = (wb_adr_i == 5'h0C);
    assign w_st    = (wb_adr_i == 5'h10);
    // A full FIFO only stalls the bus if the transmitter is not draining this cycle.
    assign w_stall = w_sel & wb_we_i & w_tx & w_full & ~w_pop;
    assign w_acc   = w_sel & ~w_stall;
    assign w_push  = w_acc & wb_we_i & w_tx;
    assign w_clr   = w_acc & wb_we_i & w_st & wb_dat_i[0];
    assign w_rdata = (w_st && !wb_we_i) ?
                     {28'b0, r_err, r_done, w_full, w_busy} : 32'b0;

    assign w_set_d = r_pushd & (r_sig == 32'h444F_4E45);
    assign w_set_e = r_pushd & (r_sig[23:0] == 24'h45_5252);

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign txd_o    = r_txd;
    assign done_o   = r_done;
    assign err_o    = r_err;

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= wb_dat_i[7:0];
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_sig   <= '0;
            r_pushd <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            r_ack   <= w_acc;
            r_dat   <= w_acc ? w_rdata : 32'b0;
            r_pushd <= w_push;
            if (w_push) r_sig <= {r_sig[23:0], wb_dat_i[7:0]};
            r_done  <= w_set_d | (r_done & ~w_clr);
            r_err   <= w_set_e | (r_err & ~w_clr);
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_txd   <= w_txd_n;
        end
    end

    assign w_end = (r_cnt == CNT_END);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + 16'd1;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_txd_n   = r_txd;
        w_pop     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                w_txd_n = 1'b1;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_shift_n = w_head;
                    w_state_n = S_START;
                    w_txd_n   = 1'b0;
                end
            end
            S_START: begin
                if (w_end) begin
                    w_state_n = S_DATA;
                    w_cnt_n   = '0;
                    w_bit_n   = '0;
                    w_txd_n   = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_end) begin
                    w_cnt_n = '0;
                    if (r_bit == 3'd7) begin
                        w_state_n = S_STOP;
                        w_txd_n   = 1'b1;
                    end else begin
                        w_bit_n = r_bit + 3'd1;
                        w_txd_n = r_shift[r_bit + 3'd1];
                    end
                end
            end
            S_STOP: begin
                if (w_end) begin
                    w_cnt_n = '0;
                    // Chain straight into the next frame so queued bytes leave no gap.
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_shift_n = w_head;
                        w_state_n = S_START;
                        w_txd_n   = 1'b0;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

endmodule
